// File: rtl/flash_bridge_pkg.sv
// Shared types and widths for the CPU-to-SPI-flash request bridge.
package flash_bridge_pkg;

    localparam int FLASH_ADDR_W = 24;
    localparam int FLASH_DATA_W = 32;
    localparam int TAG_W        = FLASH_ADDR_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_RESP
    } state_t;

endpackage

// File: rtl/flash_word_cache.sv
// Single-entry word cache: combinational lookup, registered fill; fill is ignored
// whenever flush or invalidate is asserted in the same cycle.
module flash_word_cache
    import flash_bridge_pkg::*;
#(
    parameter int TW = TAG_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [TW-1:0]           lookup_tag,
    output logic                    hit,
    output logic [FLASH_DATA_W-1:0] hit_data,
    input  logic                    fill,
    input  logic [TW-1:0]           fill_tag,
    input  logic [FLASH_DATA_W-1:0] fill_data,
    input  logic                    inval,
    input  logic                    flush
);

    logic                    line_vld;
    logic [TW-1:0]           line_tag;
    logic [FLASH_DATA_W-1:0] line_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_vld <= 1'b0;
            line_tag <= '0;
            line_dat <= '0;
        end else if (flush || inval) begin
            line_vld <= 1'b0;
        end else if (fill) begin
            line_vld <= 1'b1;
            line_tag <= fill_tag;
            line_dat <= fill_data;
        end
    end

    assign hit      = line_vld && (line_tag == lookup_tag);
    assign hit_data = line_dat;

endmodule

// File: rtl/flash_req_bridge.sv
// Sequences one word request at a time onto the flash command port; hits/misaligned
// respond next cycle, misses flash_ready+2. Holds the response until resp_ready; no request buffering.
module flash_req_bridge
    import flash_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1 << 20,
    parameter int ADDR_W         = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [FLASH_DATA_W-1:0] req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [FLASH_DATA_W-1:0] resp_rdata,
    output logic                    resp_err,
    input  logic                    cache_flush,
    output logic                    busy,
    output logic                    flash_en,
    output logic                    flash_write,
    output logic [FLASH_ADDR_W-1:0] flash_addr,
    output logic [FLASH_DATA_W-1:0] flash_data_in,
    input  logic [FLASH_DATA_W-1:0] flash_data_out,
    input  logic                    flash_ready
);

    localparam int AW_TAG = ADDR_W - 2;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        tmo_cnt;
    logic [AW_TAG-1:0]       cmd_tag;
    logic                    accept, misaligned, cache_hit, rd_hit, done, tmo;
    logic [FLASH_DATA_W-1:0] cache_rdata;

    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign misaligned = |req_addr[1:0];
    assign rd_hit     = !req_write && !misaligned && cache_hit;
    assign done       = (state == ST_ISSUE) && flash_ready;
    // flash_ready in the final allowed cycle still counts as a completion
    assign tmo        = (state == ST_ISSUE) && !flash_ready && (tmo_cnt == TMO_LAST);

    flash_word_cache #(.TW(AW_TAG)) u_cache (
        .clk        (clk),
        .rst_n      (reset_n),
        .lookup_tag (req_addr[ADDR_W-1:2]),
        .hit        (cache_hit),
        .hit_data   (cache_rdata),
        .fill       (done && !flash_write),
        .fill_tag   (cmd_tag),
        .fill_data  (flash_data_out),
        .inval      (done && flash_write),
        .flush      (cache_flush)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = (misaligned || rd_hit) ? ST_RESP : ST_ISSUE;
            ST_ISSUE: if (done || tmo) state_nxt = ST_GAP;
            ST_GAP:   state_nxt = ST_RESP;
            ST_RESP:  if (resp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flash_en      <= 1'b0;
            flash_write   <= 1'b0;
            flash_addr    <= '0;
            flash_data_in <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            tmo_cnt       <= '0;
            cmd_tag       <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    if (misaligned) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end else if (rd_hit) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= cache_rdata;
                        resp_err   <= 1'b0;
                    end else begin
                        flash_en      <= 1'b1;
                        flash_write   <= req_write;
                        flash_addr    <= FLASH_ADDR_W'(req_addr);
                        flash_data_in <= req_wdata;
                        cmd_tag       <= req_addr[ADDR_W-1:2];
                        tmo_cnt       <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (done) begin
                        flash_en   <= 1'b0;
                        resp_rdata <= flash_write ? '0 : flash_data_out;
                        resp_err   <= 1'b0;
                    end else if (tmo) begin
                        flash_en   <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ST_GAP:  resp_valid <= 1'b1;
                ST_RESP: if (resp_ready) resp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
